// File: rtl/dvi_read_sequencer.sv
// DVI raster timing generator and display-read sequencer for the frame-buffer read FIFO.
// Optional underflow event counter is enabled by defining DVI_UNDERFLOW_CNT_EN.
module dvi_read_sequencer #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int DATA_LAT        = 2,
  parameter int NEW_FRAME_WIDTH = 8,
  parameter int PREFILL_WORDS   = 256
) (
  input  logic        dvi_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [8:0]  fifo_rdusedw,
  input  logic        fifo_underflow,
  output logic        new_frame,
  output logic        read_init,
  output logic        read_rstn,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
`ifdef DVI_UNDERFLOW_CNT_EN
  output logic [15:0] underflow_cnt,
`endif
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int NF_W    = $clog2(NEW_FRAME_WIDTH + 1);

  localparam logic [H_W-1:0]  H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]  V_LAST    = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0]  H_ACT     = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0]  V_ACT     = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0]  HS_START  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]  HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]  VS_START  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]  VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [NF_W-1:0] NF_LAST   = NF_W'(NEW_FRAME_WIDTH - 1);
  localparam logic [8:0]      PREFILL_L = 9'(PREFILL_WORDS);

  typedef enum logic [2:0] {IDLE, ARM, SYNC, PREFILL, RUN} state_t;

  logic [H_W-1:0]  h_cnt_reg, h_cnt_next;
  logic [V_W-1:0]  v_cnt_reg, v_cnt_next;
  logic            vblank_next, frame_start_next;
  logic            active, hs_low, vs_low;

  state_t          state_reg;
  logic [NF_W-1:0] pulse_cnt_reg;
  logic            new_frame_reg;
  logic            read_init_reg;
  logic [15:0]     frame_cnt_reg;

  // Each stage carries {read window, hsync, vsync}; stage 0 is read_rstn timing.
  logic [2:0]      tim_pipe_reg [0:DATA_LAT];

  always_comb begin
    h_cnt_next = h_cnt_reg + 1'b1;
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_cnt_next = '0;
      v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
    end
  end

  // FSM decisions look one cycle ahead so its registered outputs line up
  // with the counter position that triggered them.
  assign vblank_next      = (h_cnt_next == '0) && (v_cnt_next == V_ACT);
  assign frame_start_next = (h_cnt_next == '0) && (v_cnt_next == '0);

  assign active = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
  assign hs_low = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
  assign vs_low = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);

  always_ff @(posedge dvi_clk) begin
    if (!reset_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  always_ff @(posedge dvi_clk) begin
    if (!reset_n) begin
      for (int i = 0; i <= DATA_LAT; i++) tim_pipe_reg[i] <= 3'b011;
    end else begin
      tim_pipe_reg[0] <= {active && read_init_reg, ~hs_low, ~vs_low};
      for (int i = 1; i <= DATA_LAT; i++) tim_pipe_reg[i] <= tim_pipe_reg[i-1];
    end
  end

  always_ff @(posedge dvi_clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      pulse_cnt_reg <= '0;
      new_frame_reg <= 1'b0;
      read_init_reg <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          new_frame_reg <= 1'b0;
          read_init_reg <= 1'b0;
          if (enable) state_reg <= ARM;
        end
        ARM: begin
          if (!enable) begin
            state_reg <= IDLE;
          end else if (vblank_next) begin
            state_reg     <= SYNC;
            new_frame_reg <= 1'b1;
            pulse_cnt_reg <= '0;
          end
        end
        SYNC: begin
          if (!enable) begin
            state_reg     <= IDLE;
            new_frame_reg <= 1'b0;
          end else if (pulse_cnt_reg == NF_LAST) begin
            state_reg     <= PREFILL;
            new_frame_reg <= 1'b0;
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
          end
        end
        PREFILL: begin
          if (!enable) begin
            state_reg <= IDLE;
          end else if ((fifo_rdusedw >= PREFILL_L) || frame_start_next) begin
            state_reg     <= RUN;
            read_init_reg <= 1'b1;
          end
        end
        RUN: begin
          if (new_frame_reg) begin
            if (pulse_cnt_reg == NF_LAST) new_frame_reg <= 1'b0;
            else                          pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
          end
          // The frame has completed at vblank start whether or not we continue.
          if (vblank_next) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
            if (enable) begin
              new_frame_reg <= 1'b1;
              pulse_cnt_reg <= '0;
            end else begin
              state_reg     <= IDLE;
              read_init_reg <= 1'b0;
              new_frame_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          new_frame_reg <= 1'b0;
          read_init_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef DVI_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt_reg;

  always_ff @(posedge dvi_clk) begin
    if (!reset_n) begin
      underflow_cnt_reg <= '0;
    end else if ((state_reg == RUN) && fifo_underflow && (underflow_cnt_reg != 16'hFFFF)) begin
      underflow_cnt_reg <= underflow_cnt_reg + 1'b1;
    end
  end

  assign underflow_cnt = underflow_cnt_reg;
`else
  logic unused_underflow;
  assign unused_underflow = fifo_underflow;
`endif

  assign new_frame = new_frame_reg;
  assign read_init = read_init_reg;
  assign frame_cnt = frame_cnt_reg;
  assign read_rstn = tim_pipe_reg[0][2];
  assign de        = tim_pipe_reg[DATA_LAT][2];
  assign hsync     = tim_pipe_reg[DATA_LAT][1];
  assign vsync     = tim_pipe_reg[DATA_LAT][0];

endmodule

// File: tb/tb_dvi_read_sequencer.sv
// Directed bench for dvi_read_sequencer using a shrunken raster (25x15 totals)
// so whole frames fit in a short run; expected values are hand-derived.
module tb_dvi_read_sequencer;

  // Raster: H 16/2/4/3 = 25, V 8/2/2/3 = 15, frame = 375 cycles.
  // Vblank start at cycle 200 of a frame, frame start every 375 cycles.
  logic        dvi_clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [8:0]  fifo_rdusedw;
  logic        fifo_underflow;
  logic        new_frame, read_init, read_rstn, hsync, vsync, de;
  logic [15:0] frame_cnt;
`ifdef DVI_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  always #5 dvi_clk = ~dvi_clk;

  dvi_read_sequencer #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .DATA_LAT(2), .NEW_FRAME_WIDTH(8), .PREFILL_WORDS(256)
  ) dut (
    .dvi_clk(dvi_clk),
    .reset_n(reset_n),
    .enable(enable),
    .fifo_rdusedw(fifo_rdusedw),
    .fifo_underflow(fifo_underflow),
    .new_frame(new_frame),
    .read_init(read_init),
    .read_rstn(read_rstn),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
`ifdef DVI_UNDERFLOW_CNT_EN
    .underflow_cnt(underflow_cnt),
`endif
    .frame_cnt(frame_cnt)
  );

  typedef struct {
    int          t;
    logic        init, nf, rstn, de, hs, vs;
    logic [15:0] fc;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  int tests = 0;
  int fails = 0;
  int t     = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, got, exp);
    end else begin
      $display("[TB] %s t=%0d ok value=%0h", name, t, got);
    end
  endtask

  function automatic logic [21:0] outs();
    return {read_init, new_frame, read_rstn, de, hsync, vsync, frame_cnt};
  endfunction

  task automatic step_to(input int target);
    while (t < target) begin
      @(negedge dvi_clk);
      t++;
    end
  endtask

  // Leaves the bench at the negedge of cycle 0 with reset just released.
  task automatic do_reset();
    reset_n        = 1'b0;
    enable         = 1'b0;
    fifo_underflow = 1'b0;
    repeat (3) @(posedge dvi_clk);
    @(negedge dvi_clk);
    t = 0;
    chk("reset_outputs", 32'(outs()), {10'd0, 6'b000011, 16'd0});
    reset_n = 1'b1;
  endtask

  initial begin
    int k;
    int de_n, hs_n, vs_n, bad_n;

    tbl[0]  = '{0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[1]  = '{200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[2]  = '{207, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[3]  = '{208, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[4]  = '{209, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[5]  = '{252, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[6]  = '{253, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[7]  = '{302, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[8]  = '{303, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[9]  = '{375, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[10] = '{376, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[11] = '{377, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[12] = '{378, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0};
    tbl[13] = '{391, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0};
    tbl[14] = '{392, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd0};
    tbl[15] = '{394, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[16] = '{396, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[17] = '{399, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[18] = '{400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[19] = '{401, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[20] = '{568, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd0};
    tbl[21] = '{569, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[22] = '{574, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[23] = '{575, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
    tbl[24] = '{582, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
    tbl[25] = '{583, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
    tbl[26] = '{949, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
    tbl[27] = '{950, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2};

    fifo_rdusedw = 9'd300;

    // Table pass: enable at reset release with a full FIFO, run two frames.
    do_reset();
    enable = 1'b1;
    k = 0; de_n = 0; hs_n = 0; vs_n = 0;
    for (int c = 0; c <= 950; c++) begin
      step_to(c);
      if (c >= 375 && c < 750) begin
        de_n += int'(de);
        hs_n += int'(!hsync);
        vs_n += int'(!vsync);
      end
      if (k < NV && tbl[k].t == c) begin
        chk($sformatf("vec%0d", k), 32'(outs()),
            32'({tbl[k].init, tbl[k].nf, tbl[k].rstn, tbl[k].de, tbl[k].hs, tbl[k].vs, tbl[k].fc}));
        k++;
      end
    end
    chk("de_cycles_per_frame", 32'(de_n), 32'd128);
    chk("hsync_low_per_frame", 32'(hs_n), 32'd60);
    chk("vsync_low_per_frame", 32'(vs_n), 32'd50);

    // Starved FIFO: readout starts at frame start, then enable drops mid-frame.
    do_reset();
    fifo_rdusedw = 9'd10;
    enable = 1'b1;
    step_to(374); chk("starved_init_before", 32'(read_init), 32'd0);
    step_to(375); chk("starved_init_at_00", 32'(read_init), 32'd1);
                  chk("starved_rstn_at_00", 32'(read_rstn), 32'd0);
    step_to(376); chk("starved_rstn_rise", 32'(read_rstn), 32'd1);
    step_to(377); chk("starved_de_before", 32'(de), 32'd0);
    step_to(378); chk("starved_de_rise", 32'(de), 32'd1);
    step_to(475); enable = 1'b0;
    step_to(566); chk("stop_rstn_last_line", 32'(read_rstn), 32'd1);
    step_to(568); chk("stop_de_last_pixel", 32'(de), 32'd1);
    step_to(574); chk("stop_init_held", 32'(read_init), 32'd1);
    bad_n = 0;
    for (int c = 575; c <= 800; c++) begin
      step_to(c);
      bad_n += int'(new_frame) + int'(read_init) + int'(de);
    end
    chk("stop_idle_quiet", 32'(bad_n), 32'd0);

    // enable dropped mid-SYNC truncates the pulse and returns to IDLE.
    do_reset();
    fifo_rdusedw = 9'd300;
    enable = 1'b1;
    step_to(203); chk("abort_nf_high", 32'(new_frame), 32'd1);
    enable = 1'b0;
    step_to(204); chk("abort_nf_cut", 32'(new_frame), 32'd0);
    step_to(209); chk("abort_no_init", 32'(read_init), 32'd0);

    // One-cycle reset during the SYNC pulse.
    do_reset();
    enable = 1'b1;
    step_to(203); chk("rst_pulse_nf_high", 32'(new_frame), 32'd1);
    reset_n = 1'b0;
    @(negedge dvi_clk);
    t = 0;
    chk("rst_pulse_outputs", 32'(outs()), {10'd0, 6'b000011, 16'd0});
    reset_n = 1'b1;
    step_to(199); chk("rst_no_partial", 32'(new_frame), 32'd0);
    step_to(200); chk("rst_pulse_restart", 32'(new_frame), 32'd1);

`ifdef DVI_UNDERFLOW_CNT_EN
    do_reset();
    fifo_rdusedw   = 9'd300;
    enable         = 1'b1;
    fifo_underflow = 1'b1;
    step_to(1);   fifo_underflow = 1'b0;
    step_to(220); fifo_underflow = 1'b1;
    step_to(221); fifo_underflow = 1'b0;
    step_to(225); fifo_underflow = 1'b1;
    step_to(226); fifo_underflow = 1'b0;
    step_to(230); fifo_underflow = 1'b1;
    step_to(231); fifo_underflow = 1'b0;
    step_to(240); chk("underflow_three", 32'(underflow_cnt), 32'd3);
    fifo_underflow = 1'b1;
    step_to(70240);
    fifo_underflow = 1'b0;
    step_to(70241); chk("underflow_saturate", 32'(underflow_cnt), 32'd65535);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dvi_read_sequencer.md
DVI_READ_SEQUENCER -- requirements
Module: dvi_read_sequencer

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 640 px; H_FP 16; H_SYNC 96; H_BP 48; V_ACTIVE 480 lines; V_FP 10; V_SYNC 2; V_BP 33; DATA_LAT 2 (cycles from rdreq to valid oData); NEW_FRAME_WIDTH 8 cycles; PREFILL_WORDS 256.
REQ-002 dvi_clk  in  1  pixel clock; all logic is on its rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 enable  in  1  request to run display readout.
REQ-005 fifo_rdusedw  in  9  read-FIFO fill level, dvi_clk domain.
REQ-006 fifo_underflow  in  1  single-cycle pulse: rdreq was issued while the read FIFO was empty.
REQ-007 new_frame  out  1  pulse that restarts the DRAM read address, stretched for clock-domain crossing.
REQ-008 read_init  out  1  read side enabled.
REQ-009 read_rstn  out  1  per-pixel read request window.
REQ-010 hsync, vsync, de  out  1 each  DVI timing, active-low syncs, aligned with oData.
REQ-011 frame_cnt  out  16  completed frames in the RUN state.
REQ-012 underflow_cnt  out  16  underflow events, present only when the macro is enabled.

Function
REQ-013 h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters; v_cnt SHALL increment when h_cnt wraps and count 0..V_TOTAL-1; both wrap to 0.
REQ-014 The active region SHALL be h_cnt < H_ACTIVE and v_cnt < V_ACTIVE; the hsync low region SHALL be H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync SHALL follow the same rule using the V parameters.
REQ-015 read_rstn SHALL be the registered active flag, one cycle after the counters, and SHALL be gated by read_init.
REQ-016 de, hsync and vsync SHALL be read_rstn timing delayed by a further DATA_LAT cycles, so that de rises on the cycle the first oData is valid.
REQ-017 The FSM SHALL have the states IDLE, ARM, SYNC, PREFILL and RUN.
REQ-018 IDLE: read_init=0, new_frame=0; the FSM moves to ARM when enable=1.
REQ-019 ARM: the FSM waits for vblank start (h_cnt=0, v_cnt=V_ACTIVE), then moves to SYNC.
REQ-020 SYNC: new_frame=1 for exactly NEW_FRAME_WIDTH cycles, then the FSM moves to PREFILL.
REQ-021 PREFILL: the FSM moves to RUN on the first cycle with fifo_rdusedw >= PREFILL_WORDS, or at frame start (h_cnt=0, v_cnt=0), whichever comes first.
REQ-022 RUN: read_init=1; at each vblank start new_frame SHALL pulse for NEW_FRAME_WIDTH cycles and frame_cnt SHALL increment, wrapping at 65535 to 0.
REQ-023 With enable=0 in RUN, the current frame SHALL complete and the FSM SHALL move to IDLE at vblank start, with no new_frame pulse.
REQ-024 enable=0 in ARM, SYNC or PREFILL SHALL return the FSM to IDLE on the next cycle; an in-progress new_frame pulse is truncated.
REQ-025 Reaching the vblank-start condition while already in SYNC SHALL NOT restart the pulse.
REQ-026 The DATA_LAT pipeline SHALL keep flushing after read_init falls; de SHALL then stay 0.

Reset
REQ-027 On reset_n=0, counters, pipelines, frame_cnt and underflow_cnt SHALL be 0 and the FSM SHALL be IDLE.
REQ-028 During reset, hsync=1, vsync=1, and de, read_rstn, read_init and new_frame SHALL all be 0.
REQ-029 Reset asserted mid-frame or mid-pulse SHALL take effect on the next edge, with no partial pulse after release.

Configuration
REQ-030 Macro DVI_UNDERFLOW_CNT_EN defined: fifo_underflow pulses seen in RUN SHALL increment underflow_cnt, saturating at 65535; underflow_cnt SHALL clear only on reset.
REQ-031 DVI_UNDERFLOW_CNT_EN undefined: the underflow_cnt port and its logic SHALL be absent and fifo_underflow SHALL be ignored.

Verification
REQ-032 Reset release, enable=1, fifo_rdusedw=300: new_frame high 8 cycles starting at v_cnt=480, h_cnt=0; read_init=1 on the cycle after new_frame falls.
REQ-033 fifo_rdusedw held at 10: read_init rises at h_cnt=0, v_cnt=0; the first read_rstn rises 1 cycle later and de rises 3 cycles after the counters reach 0,0.
REQ-034 Run 2 full frames: 800x525 timing, 640 de cycles per line, 480 de lines, 96-cycle hsync low, 2-line vsync low, frame_cnt=2.
REQ-035 enable dropped mid-frame in RUN: read_rstn continues to v_cnt=479; IDLE at v_cnt=480; no new_frame.
REQ-036 With DVI_UNDERFLOW_CNT_EN: 3 fifo_underflow pulses in RUN plus 1 in IDLE give underflow_cnt=3; 70000 pulses saturate it at 65535.
REQ-037 reset_n low for 1 cycle during the SYNC pulse: new_frame drops on the next edge and all outputs return to their reset values.
